// File: rtl/kbd_ppi_loader.sv
// 8255-style keyboard PPI over a ROWS x 12 key matrix, fed by UART FIFO key events,
// with a loader mode that streams the same FIFO bytes into memory via a select/enable write.
module kbd_ppi_loader #(
  parameter int ROWS      = 6,
  parameter int SHIFT_KEY = 64,
  parameter int AW        = 16,
  parameter int LOAD_BASE = 0,
  parameter int WR_SETUP  = 3,
  parameter int WR_PULSE  = 1,
  parameter int WR_HOLD   = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    FIFO_OUT,
  input  logic          FIFO_V_N,
  output logic          FIFO_RD,
  input  logic          LOAD_MODE,
  input  logic          E,
  input  logic          WE,
  input  logic [1:0]    ADDRESS,
  input  logic [7:0]    DIN,
  output logic [7:0]    DOUT,
  output logic [AW-1:0] W_ADDRESS,
  output logic [7:0]    W_DATA,
  output logic          W_SELECT,
  output logic          W_ENABLE,
  output logic          BUS_HOLD
);
  localparam int NK = ROWS * 12;
  localparam logic [AW-1:0] BASE = AW'(LOAD_BASE);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} st_t;

  st_t            st;
  logic [7:0]     cnt;
  logic [NK-1:0]  pressed;
  logic           shift_dn;
  logic [7:0]     pa_lat, pb_lat, pc_lat, ctrl;

  logic pa_in, pcu_in, pb_in, pcl_in;
  assign pa_in  = ctrl[4];
  assign pcu_in = ctrl[3];
  assign pb_in  = ctrl[1];
  assign pcl_in = ctrl[0];

  assign FIFO_RD = (st == IDLE) && !FIFO_V_N;

  // Drive levels: inputs float high, outputs drive their latch.
  logic [11:0]     col_drv, col_sense;
  logic [ROWS-1:0] row_drv, row_sense;

  always_comb begin
    col_drv   = '1;
    row_drv   = '1;
    col_sense = '1;
    row_sense = '1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) col_drv[c] = pcl_in | pc_lat[3-c];
      else       col_drv[c] = pa_in  | pa_lat[11-c];
    end
    for (int r = 0; r < ROWS; r++) row_drv[r] = pb_in | pb_lat[7-r];
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < 12; c++) begin
        if (pressed[r*12+c] && ((r*12+c) != SHIFT_KEY)) begin
          if (!row_drv[r]) col_sense[c] = 1'b0;
          if (!col_drv[c]) row_sense[r] = 1'b0;
        end
      end
    end
  end

  logic [7:0] pa_rd, pb_rd, pc_rd, pb_sense;

  always_comb begin
    pb_sense    = 8'hFF;
    pb_sense[1] = ~shift_dn;
    for (int r = 0; r < ROWS; r++) pb_sense[7-r] = row_sense[r];
    for (int i = 0; i < 8; i++) pa_rd[i] = pa_in ? col_sense[11-i] : pa_lat[i];
    pb_rd = pb_in ? pb_sense : pb_lat;
    pc_rd[7:4] = pcu_in ? 4'h0 : pc_lat[7:4];
    for (int j = 0; j < 4; j++) pc_rd[j] = pcl_in ? col_sense[3-j] : pc_lat[j];
    case (ADDRESS)
      2'd0:    DOUT = pa_rd;
      2'd1:    DOUT = pb_rd;
      2'd2:    DOUT = pc_rd;
      default: DOUT = ctrl;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl   <= 8'h9B;
      pa_lat <= 8'h00;
      pb_lat <= 8'h00;
      pc_lat <= 8'h00;
    end else if (E && WE) begin
      case (ADDRESS)
        2'd0: pa_lat <= DIN;
        2'd1: pb_lat <= DIN;
        2'd2: pc_lat <= DIN;
        default: begin
          if (DIN[7]) begin
            ctrl   <= DIN;
            pa_lat <= 8'h00;
            pb_lat <= 8'h00;
            pc_lat <= 8'h00;
          end else begin
            pc_lat[DIN[3:1]] <= DIN[0];
          end
        end
      endcase
    end
  end

  // Key events only arrive through an IDLE pop with LOAD_MODE low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pressed  <= '0;
      shift_dn <= 1'b0;
    end else if (FIFO_RD && !LOAD_MODE) begin
      if (FIFO_OUT == 8'h7F) begin
        pressed  <= '0;
        shift_dn <= 1'b0;
      end else if (FIFO_OUT[6:0] == 7'(SHIFT_KEY)) begin
        shift_dn <= FIFO_OUT[7];
      end else begin
        for (int k = 0; k < NK; k++)
          if (FIFO_OUT[6:0] == 7'(k)) pressed[k] <= FIFO_OUT[7];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st        <= IDLE;
      cnt       <= 8'd0;
      W_ADDRESS <= BASE;
      W_DATA    <= 8'h00;
      W_SELECT  <= 1'b0;
      W_ENABLE  <= 1'b0;
      BUS_HOLD  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (!LOAD_MODE) begin
            W_ADDRESS <= BASE;
          end else if (!FIFO_V_N) begin
            W_DATA   <= FIFO_OUT;
            W_SELECT <= 1'b1;
            BUS_HOLD <= 1'b1;
            cnt      <= 8'(WR_SETUP - 1);
            st       <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            W_ENABLE <= 1'b1;
            cnt      <= 8'(WR_PULSE - 1);
            st       <= STROBE;
          end else cnt <= cnt - 8'd1;
        end
        STROBE: begin
          if (cnt == 8'd0) begin
            W_ENABLE <= 1'b0;
            cnt      <= 8'(WR_HOLD - 1);
            st       <= HOLD;
          end else cnt <= cnt - 8'd1;
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            W_SELECT  <= 1'b0;
            BUS_HOLD  <= 1'b0;
            W_ADDRESS <= W_ADDRESS + 1'b1;
            st        <= IDLE;
          end else cnt <= cnt - 8'd1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/kbd_ppi_loader.md
# kbd_ppi_loader

Parametrised 8255-compatible keyboard/port block with an integrated FIFO-fed memory loader. Emulates the keyboard PPI (ports A/B/C plus control word, including bit set/reset) over a configurable key matrix driven by press/release events from the UART byte FIFO. In load mode the same FIFO stream is written to memory through a timed select/enable write sequence. Sits between the CPU I/O decode, the UART FIFO and the memory write arbiter.

## Interface
- ROWS, 6, matrix rows (1..6); row r senses/drives PB[7-r]
- SHIFT_KEY, 64, key index excluded from the matrix and reported directly on PB[1]
- AW, 16, loader address width
- LOAD_BASE, 0, first load address
- WR_SETUP, 3, cycles W_SELECT high before W_ENABLE (>=1)
- WR_PULSE, 1, cycles W_ENABLE high (>=1)
- WR_HOLD, 3, cycles W_SELECT high after W_ENABLE (>=1)

Ports:
- CLK  in  1  sole clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- FIFO_OUT  in  8  first-word-fall-through FIFO head byte
- FIFO_V_N  in  1  low = FIFO_OUT valid
- FIFO_RD  out  1  one-cycle pop of FIFO head
- LOAD_MODE  in  1  1 = loader, 0 = keyboard events
- E  in  1  I/O select
- WE  in  1  write strobe (with E)
- ADDRESS  in  2  register select: 0 PA, 1 PB, 2 PC, 3 control
- DIN  in  8  CPU write data
- DOUT  out  8  CPU read data, combinational on ADDRESS
- W_ADDRESS  out  AW  loader write address
- W_DATA  out  8  loader write data
- W_SELECT  out  1  memory select window
- W_ENABLE  out  1  memory write strobe
- BUS_HOLD  out  1  loader owns the memory bus

## Operation
- Key map: 12 columns; key k (0..ROWS*12-1) at row k/12, column k%12; column c<4 on PC[3-c], c>=4 on PA[11-c].
- Key state: 1 bit per key, pressed = 1. Event byte: bit7=1 press, bit7=0 release, code = bits[6:0]. Codes >= ROWS*12 and != SHIFT_KEY ignored. Byte 0x7F releases all keys.
- Drive levels: a port bit configured as output drives its latched value; configured as input it reads as 1 (pulled up).
- Column sense c = AND over rows r of (~pressed[k] | row_drive[r]); row sense r = AND over columns c of (~pressed[k] | col_drive[c]). SHIFT_KEY excluded from both.
- Read: input bits return sense, output bits return latch. PB[1] = ~pressed[SHIFT_KEY], PB[0] = 1, PB rows >= ROWS read 1; PC[7:4] reads latch if output else 0. Control reads last mode word.
- Control write, DIN[7]=1: mode set; dirs PA=DIN[4], PC upper=DIN[3], PB=DIN[1], PC lower=DIN[0] (1 = input); A/B/C latches cleared to 0x00.
- Control write, DIN[7]=0: PC latch bit DIN[3:1] <= DIN[0]; mode word unchanged.
- FSM: IDLE, SETUP, STROBE, HOLD. LOAD_MODE sampled only in IDLE.
- IDLE, LOAD_MODE=0: FIFO valid -> pop, apply event, stay IDLE. Load address reloaded to LOAD_BASE every IDLE cycle with LOAD_MODE=0.
- IDLE, LOAD_MODE=1: FIFO valid -> pop, latch W_DATA -> SETUP (W_SELECT) -> STROBE (W_SELECT, W_ENABLE) -> HOLD (W_SELECT) -> address+1 -> IDLE.
- Address wraps 2^AW-1 -> 0.

## Timing
- Reset: all keys released, control 0x9B (all input), PA/PB/PC latches 0x00, state IDLE, W_ADDRESS=LOAD_BASE, W_DATA=0x00, FIFO_RD/W_SELECT/W_ENABLE/BUS_HOLD=0.
- FIFO_RD = IDLE & ~FIFO_V_N, combinational; byte consumed at that edge, never popped twice.
- Key event visible on DOUT the cycle after the pop edge; throughput 1 event/cycle.
- Loader per byte: 1 + WR_SETUP + WR_PULSE + WR_HOLD cycles; W_ADDRESS/W_DATA stable for the whole window.
- BUS_HOLD registered, high throughout SETUP/STROBE/HOLD.
- CPU write at same edge as key event: both take effect; CPU latch update and key update are independent.
- LOAD_MODE change mid-write ignored until IDLE. Reset mid-write: outputs to reset values immediately, byte lost.
- Write to control register: DOUT for the affected port reflects new direction next cycle.

## Test plan
- Reset -> DOUT(ADDRESS=3)=0x9B, all port reads 0xFF except PC read 0x0F, BUS_HOLD=0.
- Mode 0x82 (PB input, PA/PC output), PA=0xFE (col 11 low), event 0x8B (press key 11) -> PB read 0x7F; release 0x0B -> 0xFF.
- Event 0xC0 (press SHIFT_KEY 64) -> PB[1]=0; 0x7F -> PB[1]=1 and all keys released.
- BSR write 0x07 -> PC latch bit3=1; 0x06 -> bit3=0; control readback unchanged.
- LOAD_MODE=1, FIFO bytes 0x12,0x34 -> writes at LOAD_BASE and +1, each 8 cycles, W_ENABLE high exactly 1 cycle per byte.
- AW=4, LOAD_BASE=15, two bytes -> addresses 15 then 0; reset during SETUP -> W_SELECT=0 same cycle, address 15.
